ascii_num_sep: RTL and testbench

- Receives an ASCII text packet byte-by-byte over a valid/ready stream and stores it in a payload buffer.
- After the last byte, parses the text as space-separated signed decimal integers.
- Writes each integer as a DATA_WIDTH two's-complement word to a result RAM at consecutive addresses from 0.
- Downstream logic (matrix loader) reads results through a synchronous read port and uses num_count, done and invalid.

---
 rtl/ascii_num_sep_pkg.sv | 18 +
 rtl/ascii_num_sep_parser.sv | 60 ++++++
 rtl/ascii_num_sep.sv | 111 +++++++++++
 tb/tb_ascii_num_sep.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ascii_num_sep_pkg.sv
// ascii_num_sep_pkg: shared states, ASCII constants and character classifiers
package ascii_num_sep_pkg;
  typedef enum logic [2:0] {IDLE, RECV, PARSE, DONE, ERROR} state_t;
  typedef enum logic [1:0] {T_SEP, T_NEG, T_DIG} tok_t;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  function automatic logic is_digit(input logic [7:0] c);
    return c >= CH_0 && c <= CH_9;
  endfunction
  function automatic logic is_sep(input logic [7:0] c);
    return c == CH_SP || c == CH_TAB || c == CH_CR || c == CH_LF;
  endfunction
endpackage

// File: rtl/ascii_num_sep_parser.sv
// ascii_num_sep_parser: token FSM turning a byte stream into signed integer writes
module ascii_num_sep_parser
  import ascii_num_sep_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  input  logic                  end_i,
  output logic                  wr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  err_o,
  output logic                  end_o
);
  tok_t tok_q, tok_d;
  logic neg_q, neg_d, fin;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  always_comb begin
    tok_d = tok_q;
    neg_d = neg_q;
    acc_d = acc_q;
    err_o = 1'b0;
    fin = end_i;
    if (byte_valid_i) begin
      if (is_sep(byte_i)) fin = 1'b1;
      else if (byte_i == CH_MINUS) begin
        err_o = tok_q != T_SEP;
        tok_d = T_NEG;
        neg_d = 1'b1;
      end else if (is_digit(byte_i)) begin
        tok_d = T_DIG;
        acc_d = acc_q * DATA_WIDTH'(10) + DATA_WIDTH'(byte_i - CH_0);
      end else err_o = 1'b1;
    end
    // a separator or end of buffer closes the current token
    if (fin) begin
      err_o = err_o || tok_q == T_NEG;
      tok_d = T_SEP;
      neg_d = 1'b0;
      acc_d = '0;
    end
  end
  assign wr_o = fin && tok_q == T_DIG;
  assign wr_data_o = neg_q ? -acc_q : acc_q;
  assign end_o = end_i;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      tok_q <= T_SEP;
      neg_q <= 1'b0;
      acc_q <= '0;
    end else begin
      tok_q <= tok_d;
      neg_q <= neg_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/ascii_num_sep.sv
// ascii_num_sep: buffers an ASCII packet, parses separated signed integers into a result RAM
module ascii_num_sep
  import ascii_num_sep_pkg::*;
#(
  parameter int MAX_PAYLOAD = 2048,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 2048,
  parameter int ADDR_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_clear,
  input  logic [7:0]            pkt_payload_data,
  input  logic                  pkt_payload_valid,
  input  logic                  pkt_payload_last,
  output logic                  pkt_payload_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  processing,
  output logic                  done,
  output logic                  invalid,
  output logic [ADDR_WIDTH-1:0] num_count
);
  localparam int BW = $clog2(MAX_PAYLOAD);
  localparam int PW = BW + 1;
  state_t state_q, state_d;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0] cnt_q;
  logic done_q, inv_q, ovf_q, pv_q, pe_q;
  logic [7:0] pay_mem [MAX_PAYLOAD];
  logic [7:0] pdata_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic in_parse, acc, start, full, p_wr, p_err, p_end, p_fail;
  logic [DATA_WIDTH-1:0] p_data;
  assign in_parse = state_q == PARSE;
  assign pkt_payload_ready = !in_parse;
  assign acc = pkt_payload_valid && pkt_payload_ready && !buf_clear;
  assign start = acc && state_q inside {IDLE, DONE, ERROR};
  assign full = wptr_q == PW'(MAX_PAYLOAD);
  assign p_fail = p_err || (p_wr && cnt_q == (ADDR_WIDTH+1)'(DEPTH));
  ascii_num_sep_parser #(.DATA_WIDTH(DATA_WIDTH)) u_parser (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (!in_parse),
    .byte_valid_i (pv_q && in_parse),
    .byte_i       (pdata_q),
    .end_i        (pe_q && in_parse),
    .wr_o         (p_wr),
    .wr_data_o    (p_data),
    .err_o        (p_err),
    .end_o        (p_end)
  );
  always_comb begin
    state_d = state_q;
    if (buf_clear) state_d = IDLE;
    else if (start) state_d = pkt_payload_last ? PARSE : RECV;
    else if (state_q == RECV && acc && pkt_payload_last) state_d = (ovf_q || full) ? ERROR : PARSE;
    else if (in_parse && p_fail) state_d = ERROR;
    else if (in_parse && p_end) state_d = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst || buf_clear) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      inv_q <= 1'b0;
      ovf_q <= 1'b0;
      pv_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pv_q <= in_parse && rptr_q < wptr_q;
      pe_q <= in_parse && rptr_q == wptr_q;
      if (start) begin
        wptr_q <= PW'(1);
        rptr_q <= '0;
        cnt_q <= '0;
        done_q <= 1'b0;
        inv_q <= 1'b0;
        ovf_q <= 1'b0;
      end else if (acc && state_q == RECV) begin
        // oversize packets are flagged now and drained until last
        if (full) {ovf_q, inv_q} <= 2'b11;
        else wptr_q <= wptr_q + PW'(1);
      end else if (in_parse) begin
        rptr_q <= rptr_q + PW'(rptr_q <= wptr_q);
        if (p_wr && !p_fail) cnt_q <= cnt_q + 1'b1;
        if (p_fail) inv_q <= 1'b1;
        else if (p_end) done_q <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (acc && (start || (state_q == RECV && !full)))
      pay_mem[start ? '0 : wptr_q[BW-1:0]] <= pkt_payload_data;
    pdata_q <= pay_mem[rptr_q[BW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (in_parse && p_wr && !p_fail) ram[cnt_q[ADDR_WIDTH-1:0]] <= p_data;
  end
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else rd_data <= ({1'b0, rd_addr} < cnt_q) ? ram[rd_addr] : '0;
  end
  assign processing = in_parse;
  assign done = done_q;
  assign invalid = inv_q;
  assign num_count = cnt_q[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_ascii_num_sep.sv
// tb_ascii_num_sep: scoreboard bench for the ASCII integer separator
module tb_ascii_num_sep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic buf_clear = 1'b0;
  logic [7:0] pkt_payload_data = '0;
  logic pkt_payload_valid = 1'b0;
  logic pkt_payload_last = 1'b0;
  logic pkt_payload_ready;
  logic [10:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic processing, done, invalid;
  logic [10:0] num_count;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  ascii_num_sep dut (
    .clk               (clk),
    .rst               (rst),
    .buf_clear         (buf_clear),
    .pkt_payload_data  (pkt_payload_data),
    .pkt_payload_valid (pkt_payload_valid),
    .pkt_payload_last  (pkt_payload_last),
    .pkt_payload_ready (pkt_payload_ready),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .processing        (processing),
    .done              (done),
    .invalid           (invalid),
    .num_count         (num_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // reference tokenizer: pushes expected words, returns 1 when the text is well-formed
  function automatic bit model(input string s);
    bit neg = 0, dig = 0;
    logic [31:0] a = '0;
    for (int i = 0; i <= s.len(); i++) begin
      byte c = (i == s.len()) ? 8'h20 : s[i];
      if (c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A) begin
        if (neg && !dig) return 0;
        if (dig) exp_q.push_back(neg ? -a : a);
        neg = 0; dig = 0; a = '0;
      end else if (c == "-") begin
        if (neg || dig) return 0;
        neg = 1;
      end else if (c >= "0" && c <= "9") begin
        dig = 1;
        a = a * 10 + 32'(c - 8'h30);
      end else return 0;
    end
    return 1;
  endfunction
  task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    pkt_payload_data = b;
    pkt_payload_valid = 1'b1;
    pkt_payload_last = l;
    for (int i = 0; i < 5000 && !pkt_payload_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    pkt_payload_valid = 1'b0;
    pkt_payload_last = 1'b0;
  endtask
  task automatic run_pkt(input string tag, input string s, input int gap);
    bit ok;
    int n, lat, rdbad, rdybad;
    logic [10:0] pc;
    exp_q.delete();
    ok = model(s);
    n = exp_q.size();
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], i == s.len() - 1, gap ? int'($urandom_range(0, gap)) : 0);
    lat = 0; rdbad = 0; rdybad = 0; pc = '0; rd_addr = '0;
    while (!(done || invalid) && lat < s.len() + 20) begin
      @(negedge clk);
      lat++;
      if (processing && pkt_payload_ready) rdybad++;
      if (pc != 0 && rd_data !== exp_q[0]) rdbad++;
      pc = num_count;
    end
    chk({tag, "_lat"}, 32'(lat <= s.len() + 4), 1);
    chk({tag, "_rdy_parse"}, rdybad, 0);
    chk({tag, "_rd_parse"}, rdbad, 0);
    chk({tag, "_done"}, done, ok);
    chk({tag, "_invalid"}, invalid, !ok);
    chk({tag, "_count"}, num_count, n);
    for (int i = 0; i < n; i++) begin
      rd_addr = 11'(i);
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, i), rd_data, exp_q.pop_front());
    end
    rd_addr = 11'(n);
    @(negedge clk);
    chk({tag, "_rd_oob"}, rd_data, 0);
  endtask
  task automatic pulse_clear();
    @(negedge clk);
    buf_clear = 1'b1;
    @(negedge clk);
    buf_clear = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", pkt_payload_ready, 1);
    chk("rst_proc", processing, 0);
    chk("rst_done", done, 0);
    chk("rst_inv", invalid, 0);
    chk("rst_cnt", num_count, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b0;
    run_pkt("t1", "123", 0);
    run_pkt("t2", "10 20 -30", 0);
    rd_addr = 11'd2;
    @(negedge clk);
    chk("t2_neg30", rd_data, 32'hFFFF_FFE2);
    run_pkt("t3a", "  45  -67  ", 0);
    run_pkt("t3b", "-999", 0);
    rd_addr = 11'd0;
    @(negedge clk);
    chk("t3b_neg999", rd_data, 32'hFFFF_FC19);
    run_pkt("t4a", "12a34", 0);
    run_pkt("t4b", "0 0 0", 0);
    run_pkt("minus", "-", 0);
    run_pkt("inner", "5-3", 0);
    run_pkt("dbl", "--1", 0);
    run_pkt("partial", "8 9 x", 0);
    run_pkt("seps", "   ", 0);
    run_pkt("ws", "\t1\t2\r\n3\n", 0);
    run_pkt("t5", "7 8", 0);
    pulse_clear();
    chk("clr_done", done, 0);
    chk("clr_cnt", num_count, 0);
    rd_addr = 11'd0;
    @(negedge clk);
    chk("clr_rd", rd_data, 0);
    send_byte("9", 1'b0, 0);
    send_byte("9", 1'b0, 0);
    pulse_clear();
    chk("abort_proc", processing, 0);
    run_pkt("abort", "42", 0);
    run_pkt("thr", "31 -4096 2147483647 4294967296 -2147483648 1", 3);
    for (int i = 0; i < 2049; i++) send_byte("1", i == 2048, 0);
    repeat (4) @(negedge clk);
    chk("ovf_inv", invalid, 1);
    chk("ovf_done", done, 0);
    chk("ovf_cnt", num_count, 0);
    run_pkt("post_ovf", "-5 6", 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
